// File: rtl/uart_pkg.sv
// Shared UART types and constants for the transmitter FSM and its 16x-oversampled tick counter.
// The parity state is present only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int S_CNT_W    = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start, DBIT data bits LSB first, optional parity (UART_TX_PARITY_EN), stop bits.
// tx goes low on the accepting edge; tx_start is ignored while busy (no queuing, no backpressure).
module uart_tx
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       tx_start,
  input  logic [7:0] din,
  output logic       tx_done_tick,
  output logic       tx_busy,
  output logic       tx
);

  localparam logic [S_CNT_W-1:0] S_LAST    = S_CNT_W'(OVERSAMPLE - 1);
  localparam logic [S_CNT_W-1:0] STOP_LAST = S_CNT_W'(SB_TICK - 1);
  localparam logic [2:0]         N_LAST    = 3'(DBIT - 1);

  uart_tx_state_t     state_reg, state_next;
  logic [S_CNT_W-1:0] s_reg, s_next;
  logic [2:0]         n_reg, n_next;
  logic [7:0]         b_reg, b_next;
  logic               tx_reg, tx_next;
`ifdef UART_TX_PARITY_EN
  logic               p_reg, p_next;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      b_reg     <= '0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
      tx_reg    <= tx_next;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) p_reg <= 1'b0;
    else       p_reg <= p_next;
  end
`endif

  always_comb begin
    state_next   = state_reg;
    s_next       = s_reg;
    n_next       = n_reg;
    b_next       = b_reg;
    tx_done_tick = 1'b0;
`ifdef UART_TX_PARITY_EN
    p_next       = p_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (tx_start) begin
          state_next = ST_START;
          s_next     = '0;
          b_next     = din;
`ifdef UART_TX_PARITY_EN
          p_next     = 1'b0;
`endif
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (s_reg == S_LAST) begin
            state_next = ST_DATA;
            s_next     = '0;
            n_next     = '0;
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_reg == S_LAST) begin
            s_next = '0;
            b_next = b_reg >> 1;
`ifdef UART_TX_PARITY_EN
            p_next = p_reg ^ b_reg[0];
`endif
            if (n_reg == N_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_next = ST_PARITY;
`else
              state_next = ST_STOP;
`endif
            end else begin
              n_next = n_reg + 1'b1;
            end
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (s_tick) begin
          if (s_reg == S_LAST) begin
            s_next     = '0;
            state_next = ST_STOP;
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (s_tick) begin
          if (s_reg == STOP_LAST) begin
            state_next   = ST_IDLE;
            tx_done_tick = 1'b1;
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Line level follows the state being entered, so tx moves on the same edge as the bit boundary.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = b_next[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_next = p_next ^ PARITY_ODD;
`endif
      default:   tx_next = 1'b1;
    endcase
  end

  assign tx_busy = (state_reg != ST_IDLE);
  assign tx      = tx_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboarded bench for uart_tx: two instances (8N1 even, 7-bit/2-stop odd) sharing one s_tick.
// Expected line levels per s_tick come from a frame model built from the byte and frame format.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int D0 = 8, SB0 = 16, D1 = 7, SB1 = 32;
`ifdef UART_TX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif

  typedef struct {
    int          inst;
    logic [15:0] lv;
    int          nb;
    int          stop_ticks;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din = 8'h00;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic       s_tick;
  logic [1:0] tx_w, busy_w, done_w;
  int         cyc = 0;

  exp_t expq[$];
  int   n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign s_tick = ((cyc % 4) == 3);

  uart_tx #(.DBIT(D0), .SB_TICK(SB0), .PARITY_ODD(1'b0)) dut0 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(start0), .din(din),
    .tx_done_tick(done_w[0]), .tx_busy(busy_w[0]), .tx(tx_w[0]));

  uart_tx #(.DBIT(D1), .SB_TICK(SB1), .PARITY_ODD(1'b1)) dut1 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(start1), .din(din),
    .tx_done_tick(done_w[1]), .tx_busy(busy_w[1]), .tx(tx_w[1]));

  function automatic void chk(string name, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail(string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endfunction

  // Reference frame: bit levels in line order; each held 16 ticks, then stop_ticks of idle level.
  function automatic exp_t model(int inst, logic [7:0] d);
    exp_t e;
    int   dbit = (inst == 1) ? D1 : D0;
    int   ones = 0;
    e.inst       = inst;
    e.lv         = '0;
    e.stop_ticks = (inst == 1) ? SB1 : SB0;
    for (int k = 0; k < dbit; k++) begin
      e.lv[1 + k] = d[k];
      ones += int'(d[k]);
    end
    e.nb = 1 + dbit;
    if (PBITS == 1) begin
      e.lv[e.nb] = ((ones % 2) == 1) ^ (inst == 1);
      e.nb++;
    end
    return e;
  endfunction

  function automatic int frame_ticks(int inst);
    return 16 * (1 + ((inst == 1) ? D1 : D0) + PBITS) + ((inst == 1) ? SB1 : SB0);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : mon
    logic active = 1'b0;
    int   busy_drops = 0;
    int   mism;
    logic exp_lv;
    logic lv_q[$];
    exp_t e;
    always @(negedge clk) begin
      if (reset) begin
        active = 1'b0;
        lv_q.delete();
      end else begin
        if (!active && busy_w[g]) begin
          active     = 1'b1;
          busy_drops = 0;
          lv_q.delete();
          chk($sformatf("start_low%0d", g), int'(tx_w[g]), 0);
        end
        if (active) begin
          if (!busy_w[g]) busy_drops++;
          if (s_tick) lv_q.push_back(tx_w[g]);
        end
        if (done_w[g]) begin
          if (!active || expq.size() == 0) begin
            fail($sformatf("unexpected_done%0d", g));
          end else begin
            e = expq.pop_front();
            chk($sformatf("frame_inst%0d", g), e.inst, g);
            chk($sformatf("frame_ticks%0d", g), lv_q.size(), 16 * e.nb + e.stop_ticks);
            mism = 0;
            foreach (lv_q[i]) begin
              exp_lv = (i < 16 * e.nb) ? e.lv[i / 16] : 1'b1;
              if (lv_q[i] !== exp_lv) mism++;
            end
            chk($sformatf("frame_levels%0d", g), mism, 0);
            chk($sformatf("busy_held%0d", g), busy_drops, 0);
          end
          active = 1'b0;
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic align();
    do next_cycle(); while ((cyc % 4) != 3);
  endtask

  task automatic wait_cyc(int target);
    while (cyc < target) next_cycle();
  endtask

  task automatic issue(int g, logic [7:0] d);
    din = d;
    if (g == 0) start0 = 1'b1;
    else        start1 = 1'b1;
    expq.push_back(model(g, d));
    next_cycle();
    start0 = 1'b0;
    start1 = 1'b0;
    din    = 8'($urandom);
  endtask

  // Returns in the cycle right after tx_done_tick; at = -1 when the bound expires.
  task automatic wait_done(int g, output int at);
    int n = 0;
    at = -1;
    while (n < 3000) begin
      @(negedge clk);
      if (done_w[g]) begin
        at = cyc;
        break;
      end
      n++;
    end
    if (at < 0) fail($sformatf("timeout_done%0d", g));
    next_cycle();
  endtask

  initial begin
    int          c, at;
    logic [7:0]  x, y;
    logic [7:0]  bytes[3];
    bytes = '{8'h00, 8'hFF, 8'hA3};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx", int'(tx_w), 3);
    chk("reset_busy", int'(busy_w), 0);
    chk("reset_done", int'(done_w), 0);
    reset = 1'b0;
    next_cycle();

    // 0x55 aligned to a tick: done lands exactly frame_ticks*4 clks after the start cycle
    align();
    c = cyc;
    issue(0, 8'h55);
    wait_done(0, at);
    chk("latency_dut0", at - c, 4 * frame_ticks(0));
    chk("idle_busy", int'(busy_w[0]), 0);
    chk("idle_tx", int'(tx_w[0]), 1);

    foreach (bytes[i]) begin
      issue(0, bytes[i]);
      wait_done(0, at);
    end

    issue(0, 8'h07);
    wait_done(0, at);
    issue(1, 8'h07);
    wait_done(1, at);

    // Ignored mid-data start, ignored start on done, accepted start one clk later
    align();
    c = cyc;
    issue(0, 8'h3C);
    wait_cyc(c + 300);
    start0 = 1'b1;
    din    = 8'hE1;
    next_cycle();
    start0 = 1'b0;
    wait_cyc(c + 4 * frame_ticks(0));
    x      = 8'($urandom);
    y      = x ^ 8'h5A;
    start0 = 1'b1;
    din    = x;
    next_cycle();
    din = y;
    expq.push_back(model(0, y));
    next_cycle();
    start0 = 1'b0;
    chk("back_to_back_busy", int'(busy_w[0]), 1);
    wait_done(0, at);

    // Reset during data bit 3
    align();
    c = cyc;
    issue(0, 8'hC3);
    wait_cyc(c + 290);
    reset = 1'b1;
    #1;
    chk("midreset_tx", int'(tx_w[0]), 1);
    chk("midreset_busy", int'(busy_w[0]), 0);
    chk("midreset_done", int'(done_w[0]), 0);
    expq.delete(expq.size() - 1);
    next_cycle();
    next_cycle();
    reset = 1'b0;
    next_cycle();
    chk("postreset_busy", int'(busy_w[0]), 0);
    issue(0, 8'h96);
    wait_done(0, at);

    // 7 data bits, 2 stop bits: bit 7 of 0x80 must not appear
    align();
    c = cyc;
    issue(1, 8'h80);
    wait_done(1, at);
    chk("latency_dut1", at - c, 4 * frame_ticks(1));

    repeat (8) begin
      int g;
      g = int'($urandom_range(0, 1));
      repeat ($urandom_range(0, 5)) next_cycle();
      issue(g, 8'($urandom));
      wait_done(g, at);
    end

    repeat (4) next_cycle();
    chk("queue_empty", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
